serial_deframer: RTL
====================

// Module: serial_deframer
// PURPOSE
//  Downstream consumer of the 4-bit PISO shifter: rebuilds parallel words from its MSB-first
//  serial stream. A sync strobe marks each frame's first bit; completed words are double-buffered
//  and offered on a valid/ready port to the next stage. Flags resync and overflow errors.
// PARAMETERS
//  WIDTH   4   data bits per frame, MSB first; legal range 2..32
//  CNT_W   localparam = $clog2(WIDTH+1); bit-counter width
// PORTS
//  clk        in   1      clock; all logic on posedge
//  rst        in   1      reset, synchronous, active-high
//  sdata      in   1      serial data bit, sampled only when bit_en=1
//  bit_en     in   1      bit strobe; one bit per cycle at most
//  sync       in   1      qualifies sdata as first (MSB) bit of frame; ignored when bit_en=0
//  out_data   out  WIDTH  assembled word, stable while out_valid=1
//  out_valid  out  1      holding register full
//  out_ready  in   1      consumer accepts word when out_valid&&out_ready
//  out_perr   out  1      parity error tag for out_data (0 when PARITY_CHECK_EN undefined)
//  frame_err  out  1      one-cycle pulse: frame aborted by early sync
//  ovf        out  1      sticky: completed word dropped because holding reg full
//  ovf_clr    in   1      clears ovf
//  busy       out  1      1 when state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, shift reg=0, out_data=0, out_valid=0, out_perr=0, frame_err=0, ovf=0.
//    rst mid-frame discards partial word and any held word; no frame_err.
//  - IDLE: bit_en&&sync -> sreg={..,sdata}, cnt=1, go SHIFT. bit_en without sync ignored.
//  - SHIFT: bit_en -> sreg={sreg[WIDTH-2:0],sdata}, cnt+1. Bit WIDTH received -> word complete:
//    go IDLE (or PARITY if enabled). bit_en=0 holds state (no timeout).
//  - Early sync (bit_en&&sync in SHIFT/PARITY): discard partial, pulse frame_err next cycle,
//    restart with this bit as MSB, cnt=1, stay/enter SHIFT.
//  - Sync coinciding with the final bit is an early sync, not a completion (word discarded).
//  - Completion: word enters holding reg at the edge sampling its last bit; out_valid=1 next
//    cycle (latency 1 from last strobe). Load allowed if out_valid=0 or out_valid&&out_ready
//    same cycle (zero-bubble); otherwise word dropped, held word kept, ovf<=1.
//  - ovf: set beats ovf_clr when both occur same cycle.
//  - out_valid falls the cycle after out_valid&&out_ready unless refilled that edge.
//  - out_data/out_perr never change while out_valid=1 and out_ready=0.
//  - Back-to-back: a new sync bit the cycle after completion is accepted (IDLE).
// CONFIGURATION
//  PARITY_CHECK_EN defined: after WIDTH data bits state PARITY awaits one more bit_en; that bit
//    is even parity; out_perr = ^{data,pbit}; completion occurs on the parity bit.
//  Undefined: no PARITY state, frame = WIDTH bits, out_perr tied 0.
// STRUCTURE
//  Shared header serial_pkg.vh: state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PARITY=2'd2;
//    default WIDTH constant shared with the PISO shifter.
//  One sub-module: deframer_hold_reg (1-entry valid/ready holding register with drop/ovf
//    output); FSM, counter and shift register stay in top.
// TESTING
//  1 WIDTH=4, sync+bits 1,0,1,1 on consecutive strobes, out_ready=1 -> out_data=4'hB,
//    out_valid one cycle, 1 cycle after last strobe.
//  2 Bits 1,1 then sync+0,1,1,0 -> frame_err pulse once, out_data=4'h6, no word 4'hC.
//  3 out_ready=0, send 4'hA then 4'h5 -> out_data stays 4'hA, ovf=1; ovf_clr -> ovf=0.
//  4 out_ready=1, two frames back-to-back (4'h3, 4'hC) -> both delivered in order, no ovf.
//  5 rst asserted after 2 bits of a frame -> busy=0, out_valid=0, frame_err=0; next frame 4'h9 OK.
//  6 PARITY_CHECK_EN: 4'h7 + pbit 1 -> out_perr=0; 4'h7 + pbit 0 -> out_perr=1.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial deframer and its PISO peer.
// State encodings and the default frame width live here.
package serial_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/deframer_hold_reg.sv
// One-entry valid/ready holding register for assembled words.
// A word arriving while the entry is full and not draining is dropped; ovf is sticky.
module deframer_hold_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_perr,
    input  logic             out_ready,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_perr,
    output logic             ovf
);

    logic load;
    logic drop;

    assign load = in_valid && (!out_valid || out_ready);
    assign drop = in_valid && !load;

    // Hold the word until consumed; refill on the same edge as a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_perr  <= 1'b0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= in_data;
            out_perr  <= in_perr;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overflow; a new drop wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_deframer.sv
// Rebuilds MSB-first serial frames into parallel words behind a valid/ready port.
// Optional trailing even-parity bit: define PARITY_CHECK_EN.
module serial_deframer
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sdata,
    input  logic             bit_en,
    input  logic             sync,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_perr,
    output logic             frame_err,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_n;
    logic [WIDTH-1:0] shifted;
    logic             ferr_n;
    logic             done;
    logic [WIDTH-1:0] word;
    logic             word_perr;

    assign shifted = {sreg[WIDTH-2:0], sdata};
    assign busy    = (state != ST_IDLE);

    // Frame state, bit counter, shift register and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sreg      <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sreg      <= sreg_n;
            frame_err <= ferr_n;
        end
    end

    // Next state: sync always restarts a frame; a completed word is offered as done.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sreg_n    = sreg;
        ferr_n    = 1'b0;
        done      = 1'b0;
        word      = shifted;
        word_perr = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bit_en && sync) begin
                    sreg_n  = shifted;
                    cnt_n   = CNT_W'(1);
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_en && sync) begin
                    sreg_n = shifted;
                    cnt_n  = CNT_W'(1);
                    ferr_n = 1'b1;
                end else if (bit_en) begin
                    sreg_n = shifted;
                    cnt_n  = cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
                        state_n = ST_PARITY;
`else
                        done    = 1'b1;
                        cnt_n   = '0;
                        state_n = ST_IDLE;
`endif
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            ST_PARITY: begin
                word = sreg;
                if (bit_en && sync) begin
                    sreg_n  = shifted;
                    cnt_n   = CNT_W'(1);
                    ferr_n  = 1'b1;
                    state_n = ST_SHIFT;
                end else if (bit_en) begin
                    done      = 1'b1;
                    word_perr = ^{sreg, sdata};
                    cnt_n     = '0;
                    state_n   = ST_IDLE;
                end
            end
`endif
            default: begin
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    deframer_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (done),
        .in_data  (word),
        .in_perr  (word_perr),
        .out_ready(out_ready),
        .ovf_clr  (ovf_clr),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_perr (out_perr),
        .ovf      (ovf)
    );

endmodule
